// File: rtl/dt_pkg.sv
// Shared types and constants for the temperature sample controller.
package dt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        REQ,
        FAULT
    } dt_state_t;

    // Signed Q7.0 temperature sample
    typedef logic signed [7:0] dt_sample_t;

    localparam dt_sample_t T_MIN = -8'sd40;
    localparam dt_sample_t T_MAX = 8'sd125;

    // A period of 0 behaves like a period of 1.
    function automatic logic [15:0] period_reload(input logic [15:0] period);
        return (period == 16'd0) ? 16'd0 : period - 16'd1;
    endfunction

endpackage

// File: rtl/dt_period_timer.sv
// Loadable down-counter for the sample period; zero flags the terminal count.
module dt_period_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != 16'd0)) begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/dt_sample_ctrl.sv
// Periodic sensor sampling with ack timeout, retries and sticky fault.
// Optional range rejection of samples: define DT_SAMPLE_CTRL_RANGE_CHK_EN.
//
// state     | meaning
// IDLE      | scheduler disabled, waiting for en
// WAIT_TICK | period counter running down to the next request
// REQ       | sens_req high, waiting for sens_ack with timeout/retry
// FAULT     | retries exhausted, fault high until en drops
module dt_sample_ctrl
    import dt_pkg::*;
#(
    parameter logic [7:0]  TIMEOUT_CYC = 8'd200,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [15:0]        period,
    output logic               sens_req,
    input  logic               sens_ack,
    input  logic signed [7:0]  sens_data,
    output logic signed [7:0]  T_cur,
    output logic               est_ce,
    output logic               est_init,
    output logic               fault,
    output logic [7:0]         err_cnt
);

    localparam logic [7:0] MAX_RETRY_W = MAX_RETRY[7:0];

    dt_state_t  state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] retry_q, retry_d;
    logic       first_q, first_d;
    dt_sample_t t_cur_q, t_cur_d;
    logic       est_ce_q, est_ce_d;
    logic       est_init_q, est_init_d;
    logic [7:0] err_q;
    logic       err_inc;
    logic       tmr_load, tmr_dec, tmr_zero;
    logic       sample_ok;

    dt_period_timer u_period_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (period_reload(period)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

`ifdef DT_SAMPLE_CTRL_RANGE_CHK_EN
    assign sample_ok = (dt_sample_t'(sens_data) >= T_MIN) && (dt_sample_t'(sens_data) <= T_MAX);
`else
    assign sample_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        first_d    = first_q;
        t_cur_d    = t_cur_q;
        est_ce_d   = 1'b0;
        est_init_d = 1'b0;
        err_inc    = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;

        // Dropping en aborts everything, including a same-cycle ack.
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = WAIT_TICK;
                    tmr_load = 1'b1;
                    first_d  = 1'b1;
                end
                WAIT_TICK: begin
                    if (tmr_zero) begin
                        state_d = REQ;
                        tmo_d   = '0;
                        retry_d = '0;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                REQ: begin
                    // Ack beats a timeout landing on the same cycle.
                    if (sens_ack) begin
                        state_d  = WAIT_TICK;
                        tmr_load = 1'b1;
                        if (sample_ok) begin
                            t_cur_d    = dt_sample_t'(sens_data);
                            est_init_d = first_q;
                            est_ce_d   = !first_q;
                            first_d    = 1'b0;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (tmo_q == TIMEOUT_CYC - 8'd1) begin
                        err_inc = 1'b1;
                        tmo_d   = '0;
                        if (retry_q == MAX_RETRY_W) begin
                            state_d = FAULT;
                        end else begin
                            retry_d = retry_q + 8'd1;
                        end
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            retry_q    <= '0;
            first_q    <= 1'b1;
            t_cur_q    <= '0;
            est_ce_q   <= 1'b0;
            est_init_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            first_q    <= first_d;
            t_cur_q    <= t_cur_d;
            est_ce_q   <= est_ce_d;
            est_init_q <= est_init_d;
            if (err_inc && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign sens_req = (state_q == REQ);
    assign fault    = (state_q == FAULT);
    assign T_cur    = t_cur_q;
    assign est_ce   = est_ce_q;
    assign est_init = est_init_q;
    assign err_cnt  = err_q;

endmodule
